// File: rtl/pwm_bus_master.sv
// rtl/pwm_bus_master.sv - cs/rd/data bus initiator that issues write, read and write-verify cycles to the PWM CSR
module pwm_bus_master #(
    parameter int          WR_CYCLES   = 2,
    parameter int          RD_CYCLES   = 3,
    parameter int          GAP_CYCLES  = 2,
    parameter logic [15:0] VERIFY_MASK = 16'hFFFF
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_verify,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        cs,
    output logic        rd,
    inout  wire  [15:0] data
);

    typedef enum logic [2:0] {IDLE, WR, WR_GAP, RD, RD_GAP} state_t;

    localparam logic [7:0] WR_LAST  = 8'(WR_CYCLES - 1);
    localparam logic [7:0] RD_LAST  = 8'(RD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [15:0] wr_data_q;
    logic [15:0] rd_data_q;
    logic        write_q;
    logic        verify_q;
    logic        data_oe;

    assign data = data_oe ? wr_data_q : 16'bz;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cmd_valid && cmd_ready) state_n = cmd_write ? WR : RD;
            WR:      if (cnt == WR_LAST) state_n = WR_GAP;
            WR_GAP:  if (cnt == GAP_LAST) state_n = verify_q ? RD : IDLE;
            RD:      if (cnt == RD_LAST) state_n = RD_GAP;
            RD_GAP:  if (cnt == GAP_LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        cnt_n = (state_n != state || state == IDLE) ? 8'd0 : cnt + 8'd1;
    end

    // Outputs are registered from the next state so the bus pins change on the same edge as the state.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            cs        <= 1'b0;
            rd        <= 1'b0;
            data_oe   <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 16'h0000;
            rsp_err   <= 1'b0;
            wr_data_q <= 16'h0000;
            rd_data_q <= 16'h0000;
            write_q   <= 1'b0;
            verify_q  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cs        <= (state_n == WR) || (state_n == RD);
            // rd outlives cs by one gap cycle so the responder never sees rd fall under an active cs
            rd        <= (state_n == RD) || (state == RD && state_n == RD_GAP);
            data_oe   <= (state_n == WR);
            cmd_ready <= (state_n == IDLE);
            busy      <= (state_n != IDLE);
            rsp_valid <= (state != IDLE) && (state_n == IDLE);
            if (state == IDLE && state_n != IDLE) begin
                wr_data_q <= cmd_data;
                write_q   <= cmd_write;
                verify_q  <= cmd_write && cmd_verify;
            end
            if (state == RD && state_n == RD_GAP)
                rd_data_q <= data;
            if (state != IDLE && state_n == IDLE) begin
                rsp_data <= (write_q && !verify_q) ? wr_data_q : rd_data_q;
                rsp_err  <= verify_q && (|((rd_data_q ^ wr_data_q) & VERIFY_MASK));
            end
        end
    end

endmodule
